crc_burst_gen: RTL and testbench

//  Parametrised DDR5 write-CRC generator for the write data path. Accepts 2*N data bits
//  per clock (two DQ beats) from the write data block and runs one CRC-8 engine per
//  8-bit lane slice across a full burst. On the last beat it registers all lane CRCs,

---
 rtl/crc_burst_gen.sv | 117 +++++++++++
 tb/tb_crc_burst_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/crc_burst_gen.sv
// DDR5 write-CRC generator: one CRC-8 engine per 8-bit lane across a full or chopped burst.
// Lane codes are registered on the last data clock and flagged with a one-cycle valid.
module crc_burst_gen #(
  parameter int unsigned N          = 16,
  parameter int unsigned BURST_CLKS = 8,
  parameter int unsigned CHOP_CLKS  = 4,
  parameter logic [7:0]  POLY       = 8'h07,
  parameter logic [7:0]  INIT       = 8'h00
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_crc_en,
  input  logic           i_crc_clear,
  input  logic           i_burst_chop,
  input  logic [2*N-1:0] i_crc_in_data,
  output logic [2*N-1:0] o_crc_code,
  output logic           o_crc_valid,
  output logic           o_busy
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned L  = W / 8;
  localparam int unsigned CW = $clog2(BURST_CLKS + 1);
  localparam logic [W-1:0] INIT_ALL = {L{INIT}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chop_q, chop_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  code_q, code_d;
  logic          valid_q, valid_d;

  logic          chop_sel;
  logic [CW-1:0] last_cnt;
  logic [W-1:0]  acc_seed;
  logic [W-1:0]  acc_step;

  // Eight serial LFSR steps, data bit 0 first.
  function automatic logic [7:0] crc8_step(input logic [7:0] acc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = acc;
    for (int i = 0; i < 8; i++) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chop_d   = chop_q;
    acc_d    = acc_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    acc_seed = (state_q == IDLE) ? INIT_ALL : acc_q;
    acc_step = '0;

    // Chop only counts on the first enabled clock; afterwards the latched copy rules.
    chop_sel = (state_q == IDLE) ? i_burst_chop : chop_q;
    last_cnt = chop_sel ? CW'(CHOP_CLKS - 1) : CW'(BURST_CLKS - 1);

    for (int k = 0; k < int'(L); k++) begin
      acc_step[8*k +: 8] = crc8_step(acc_seed[8*k +: 8], i_crc_in_data[8*k +: 8]);
    end

    if (i_crc_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      chop_d  = 1'b0;
      acc_d   = INIT_ALL;
    end else if (i_crc_en) begin
      if (cnt_q == last_cnt) begin
        code_d  = acc_step;
        valid_d = 1'b1;
        cnt_d   = '0;
        chop_d  = 1'b0;
        acc_d   = INIT_ALL;
        state_d = IDLE;
      end else begin
        acc_d   = acc_step;
        cnt_d   = cnt_q + CW'(1);
        chop_d  = chop_sel;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chop_q  <= 1'b0;
      acc_q   <= INIT_ALL;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chop_q  <= chop_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign o_crc_code  = code_q;
  assign o_crc_valid = valid_q;
  assign o_busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_crc_burst_gen.sv
// Directed bench for crc_burst_gen: x16, x8 and x4 instances share one stimulus stream.
module tb_crc_burst_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        chop;
  logic [31:0] din;

  logic [31:0] code16;
  logic [15:0] code8;
  logic [7:0]  code4;
  logic        valid16, valid8, valid4;
  logic        busy16, busy8, busy4;

  int unsigned n_cmp;
  int unsigned n_bad;

  crc_burst_gen #(.N(16)) u_dut16 (
    .i_clk(clk), .i_reset(rst), .i_crc_en(en), .i_crc_clear(clr), .i_burst_chop(chop),
    .i_crc_in_data(din), .o_crc_code(code16), .o_crc_valid(valid16), .o_busy(busy16)
  );

  crc_burst_gen #(.N(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_crc_en(en), .i_crc_clear(clr), .i_burst_chop(chop),
    .i_crc_in_data(din[15:0]), .o_crc_code(code8), .o_crc_valid(valid8), .o_busy(busy8)
  );

  crc_burst_gen #(.N(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_crc_en(en), .i_crc_clear(clr), .i_burst_chop(chop),
    .i_crc_in_data(din[7:0]), .o_crc_code(code4), .o_crc_valid(valid4), .o_busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1ns after the capturing edge.
  task automatic step(input logic e, input logic c, input logic ch, input logic [31:0] d);
    en   = e;
    clr  = c;
    chop = ch;
    din  = d;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  // Zero-data beats followed by one last beat; valid must stay low until the last.
  task automatic burst(input string tag, input int unsigned len, input logic ch,
                       input logic [31:0] last_d);
    for (int i = 0; i < int'(len) - 1; i++) begin
      step(1'b1, 1'b0, (i == 0) ? ch : 1'b0, 32'h0);
      check({tag, "_early_valid"}, 32'(valid4), 32'h0);
    end
    step(1'b1, 1'b0, (len == 1) ? ch : 1'b0, last_d);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    chop  = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_code16", code16, 32'h0);
    check("rst_valid16", 32'(valid16), 32'h0);
    check("rst_busy16", 32'(busy16), 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // All-zero full burst on x16
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("t1_busy16", 32'(busy16), 32'h1);
    check("t1_valid16_pre", 32'(valid16), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("t1_valid16", 32'(valid16), 32'h1);
    check("t1_code16", code16, 32'h0);
    check("t1_busy16_done", 32'(busy16), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("t1_valid16_pulse", 32'(valid16), 32'h0);

    // Lane independence: alternating 80/40 lanes
    burst("t1b", 8, 1'b0, 32'h4080_4080);
    check("t1b_code16", code16, 32'h0E07_0E07);
    check("t1b_code8", 32'(code8), 32'h0E07);
    check("t1b_code4", 32'(code4), 32'h07);
    check("t1b_valid4", 32'(valid4), 32'h1);

    // Single set bit in bit 6 of the last beat
    burst("t2", 8, 1'b0, 32'h0000_0040);
    check("t2_code4", 32'(code4), 32'h0E);
    check("t2_code16", code16, 32'h0000_000E);

    // Chopped burst; chop is dropped after the first clock and must be ignored
    burst("t3", 4, 1'b1, 32'h0000_4080);
    check("t3_valid8", 32'(valid8), 32'h1);
    check("t3_code8", 32'(code8), 32'h0E07);
    check("t3_code16", code16, 32'h0000_0E07);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("t3_busy8_after", 32'(busy8), 32'h0);
    check("t3_code8_hold", 32'(code8), 32'h0E07);

    // Gapped enable: gaps after beats 2, 4, 6
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, (i == 7) ? 32'h0000_0080 : 32'h0);
      if (i == 1 || i == 3 || i == 5) begin
        step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        check("t4_gap_valid", 32'(valid4), 32'h0);
        check("t4_gap_busy", 32'(busy4), 32'h1);
      end
    end
    check("t4_valid4", 32'(valid4), 32'h1);
    check("t4_code4", 32'(code4), 32'h07);

    // Back-to-back bursts with no idle clock
    burst("t5a", 8, 1'b0, 32'h0000_0080);
    check("t5a_valid4", 32'(valid4), 32'h1);
    check("t5a_code4", 32'(code4), 32'h07);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("t5b_mid_valid", 32'(valid4), 32'h0);
      check("t5b_hold_code", 32'(code4), 32'h07);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0000_0040);
    check("t5b_valid4", 32'(valid4), 32'h1);
    check("t5b_code4", 32'(code4), 32'h0E);

    // Clear (with enable asserted) after 5 nonzero clocks
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("t6_clr_valid", 32'(valid4), 32'h0);
    check("t6_clr_busy", 32'(busy4), 32'h0);
    check("t6_clr_code", 32'(code4), 32'h0E);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t6_idle_clr_busy", 32'(busy4), 32'h0);
    burst("t6a", 8, 1'b0, 32'h0000_0080);
    check("t6a_valid4", 32'(valid4), 32'h1);
    check("t6a_code4", 32'(code4), 32'h07);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    check("t6r_code4", 32'(code4), 32'h0);
    check("t6r_busy4", 32'(busy4), 32'h0);
    check("t6r_valid4", 32'(valid4), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    burst("t6b", 8, 1'b0, 32'h0000_0080);
    check("t6b_valid4", 32'(valid4), 32'h1);
    check("t6b_code4", 32'(code4), 32'h07);
    check("t6b_code16", code16, 32'h0000_0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
